// File: rtl/light_package.sv
// Shared light colours and defaults for the two-street
// traffic light controller and its environment models.
package light_package;

  typedef enum logic [1:0] {
    red,
    yellow,
    green
  } colors;

  parameter int PASS_CYC_DEF = 2;

  // Holding a colour is always fine; otherwise only g->y->r->g.
  function automatic logic step_ok(
    input colors from,
    input colors to
  );
    logic ok;
    ok = 1'b0;
    if (from == to) begin
      ok = 1'b1;
    end else begin
      unique case (from)
        red:     ok = (to == green);
        yellow:  ok = (to == red);
        green:   ok = (to == yellow);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/tlc_lane_queue.sv
// One street's car queue: saturating counter, green-light
// pass timer and light sequence checker.
module tlc_lane_queue
  import light_package::*;
#(
  parameter int QW       = 4,
  parameter int PASS_CYC = PASS_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr,
  input  colors         light,
  output logic [QW-1:0] cnt,
  output logic          busy,
  output logic          ovf,
  output logic          seq_err
);

  localparam int TW = (PASS_CYC > 1) ? $clog2(PASS_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(PASS_CYC - 1);
  localparam logic [QW-1:0] MAX  = '1;

  logic [TW-1:0] ptmr;
  colors         prev;
  logic          active;
  logic          dep;
  logic          full;

  assign busy   = (cnt != '0);
  assign active = (light == green) && busy;
  assign dep    = active && (ptmr == LAST);
  assign full   = (cnt == MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ptmr    <= '0;
      ovf     <= 1'b0;
      seq_err <= 1'b0;
      prev    <= red;
    end else begin
      // Partial green time is discarded on any interruption.
      ptmr <= (active && !dep) ? ptmr + 1'b1 : '0;
      if (arr && !dep) begin
        if (full) ovf <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end else if (dep && !arr) begin
        cnt <= cnt - 1'b1;
      end
      if (!step_ok(prev, light)) seq_err <= 1'b1;
      prev <= light;
    end
  end

endmodule

// File: rtl/tlc_lane_sensor.sv
// Environment model for the traffic light controller:
// two car queues plus a both-not-red safety monitor.
module tlc_lane_sensor
  import light_package::*;
#(
  parameter int QW       = 4,
  parameter int PASS_CYC = PASS_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr_a,
  input  logic          arr_b,
  input  colors         La,
  input  colors         Lb,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] cnt_a,
  output logic [QW-1:0] cnt_b,
  output logic [1:0]    ovf,
  output logic          unsafe,
  output logic          seq_err
);

  logic seq_a;
  logic seq_b;

  tlc_lane_queue #(
    .QW       (QW),
    .PASS_CYC (PASS_CYC)
  ) u_lane_a (
    .clk     (clk),
    .reset   (reset),
    .arr     (arr_a),
    .light   (La),
    .cnt     (cnt_a),
    .busy    (Ta),
    .ovf     (ovf[0]),
    .seq_err (seq_a)
  );

  tlc_lane_queue #(
    .QW       (QW),
    .PASS_CYC (PASS_CYC)
  ) u_lane_b (
    .clk     (clk),
    .reset   (reset),
    .arr     (arr_b),
    .light   (Lb),
    .cnt     (cnt_b),
    .busy    (Tb),
    .ovf     (ovf[1]),
    .seq_err (seq_b)
  );

  assign seq_err = seq_a | seq_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unsafe <= 1'b0;
    end else if ((La != red) && (Lb != red)) begin
      unsafe <= 1'b1;
    end
  end

endmodule
